// File: rtl/pack_drain_ctrl.sv
// pack_drain_ctrl: drains packBuild elements over DataReady/DataNext and frames them
// as header, sequence, payload (LO then HI) and status bytes on a valid/ready stream.
module pack_drain_ctrl #(
  parameter int          FRAME_WORDS = 8,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int          RD_LAT      = 1,
  parameter int          TIMEOUT     = 1024,
  parameter logic [15:0] PAD_WORD    = 16'h7FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] DataVal,
  input  logic        DataReady,
  input  logic        DataOverf,
  output logic        DataNext,
  output logic        DataFrameReset,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] frames_sent
);

  // state | meaning
  // IDLE  | waiting for enable && DataReady, or an overflow to flush
  // HDR   | emitting HDR_BYTE
  // SEQ   | emitting the frame sequence number
  // REQ   | requesting the next element, or padding after a timeout
  // WAIT  | waiting out the packBuild read latency
  // LO    | emitting element bits [7:0]
  // HI    | emitting element bits [15:8]
  // STAT  | emitting {ovfFlag, toFlag, 6'd0}
  // FLUSH | one-cycle DataFrameReset pulse
  typedef enum logic [3:0] {IDLE, HDR, SEQ, REQ, WAIT, LO, HI, STAT, FLUSH} stateT;

  localparam logic [15:0] TICK_LOAD = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LAT_LOAD  = 2'(RD_LAT);
  localparam logic [7:0]  LAST_WORD = 8'(FRAME_WORDS - 1);

  stateT       state;
  logic [7:0]  seqNum;
  logic        ovfFlag;
  logic        toFlag;
  logic [7:0]  wordCnt;
  logic [15:0] tickCnt;
  logic [1:0]  latCnt;
  logic [15:0] wordReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      seqNum         <= 8'd0;
      ovfFlag        <= 1'b0;
      toFlag         <= 1'b0;
      wordCnt        <= 8'd0;
      tickCnt        <= 16'd0;
      latCnt         <= 2'd0;
      wordReg        <= 16'd0;
      DataNext       <= 1'b0;
      DataFrameReset <= 1'b0;
      out_data       <= 8'd0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      frames_sent    <= 16'd0;
    end else begin
      DataNext       <= 1'b0;
      DataFrameReset <= 1'b0;
      case (state)
        IDLE: begin
          if (DataOverf) begin
            state          <= FLUSH;
            DataFrameReset <= 1'b1;
            busy           <= 1'b1;
          end else if (enable && DataReady) begin
            state     <= HDR;
            out_valid <= 1'b1;
            out_data  <= HDR_BYTE;
            busy      <= 1'b1;
          end
        end
        HDR: begin
          if (out_ready) begin
            state    <= SEQ;
            out_data <= seqNum;
          end
        end
        SEQ: begin
          if (out_ready) begin
            state     <= REQ;
            out_valid <= 1'b0;
            tickCnt   <= TICK_LOAD;
          end
        end
        // tickCnt is a down-counter; reaching zero while still starved is the timeout
        REQ: begin
          if (toFlag) begin
            wordReg   <= PAD_WORD;
            out_data  <= PAD_WORD[7:0];
            out_valid <= 1'b1;
            state     <= LO;
          end else if (DataReady) begin
            DataNext <= 1'b1;
            latCnt   <= LAT_LOAD;
            state    <= WAIT;
          end else if (tickCnt == 16'd0) begin
            toFlag    <= 1'b1;
            wordReg   <= PAD_WORD;
            out_data  <= PAD_WORD[7:0];
            out_valid <= 1'b1;
            state     <= LO;
          end else begin
            tickCnt <= tickCnt - 16'd1;
          end
        end
        WAIT: begin
          if (latCnt == 2'd0) begin
            wordReg   <= DataVal;
            out_data  <= DataVal[7:0];
            out_valid <= 1'b1;
            state     <= LO;
          end else begin
            latCnt <= latCnt - 2'd1;
          end
        end
        LO: begin
          if (out_ready) begin
            out_data <= wordReg[15:8];
            state    <= HI;
          end
        end
        HI: begin
          if (out_ready) begin
            wordCnt <= wordCnt + 8'd1;
            if (wordCnt == LAST_WORD) begin
              state    <= STAT;
              out_data <= {ovfFlag | DataOverf, toFlag, 6'd0};
            end else begin
              state     <= REQ;
              out_valid <= 1'b0;
              tickCnt   <= TICK_LOAD;
            end
          end
        end
        STAT: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            seqNum      <= seqNum + 8'd1;
            frames_sent <= frames_sent + 16'd1;
            toFlag      <= 1'b0;
            wordCnt     <= 8'd0;
            // an overflow that arrived after the status byte was latched stays pending
            ovfFlag     <= ovfFlag & ~out_data[7];
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (DataOverf) ovfFlag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pack_drain_ctrl.sv
// Bench for pack_drain_ctrl: FIFO model plus expected-byte scoreboard built from the
// frame format, checked on every accepted byte and every stall cycle.
module tb_pack_drain_ctrl;
  localparam int          FRAME_WORDS = 8;
  localparam logic [7:0]  HDR_BYTE    = 8'hA5;
  localparam int          RD_LAT      = 1;
  localparam int          TIMEOUT     = 16;
  localparam logic [15:0] PAD_WORD    = 16'h7FFF;

  typedef logic [15:0] frameT [FRAME_WORDS];

  logic        clk, rst, enable, DataReady, DataOverf, DataNext, DataFrameReset;
  logic        out_valid, out_ready, busy;
  logic [15:0] DataVal, frames_sent;
  logic [7:0]  out_data;

  pack_drain_ctrl #(
    .FRAME_WORDS(FRAME_WORDS), .HDR_BYTE(HDR_BYTE), .RD_LAT(RD_LAT),
    .TIMEOUT(TIMEOUT), .PAD_WORD(PAD_WORD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .DataVal(DataVal), .DataReady(DataReady),
    .DataOverf(DataOverf), .DataNext(DataNext), .DataFrameReset(DataFrameReset),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] fifoQ[$];
  logic [7:0]  expQ[$];
  logic [7:0]  gotQ[$];
  int acceptCnt = 0, nextCnt = 0, frCnt = 0;
  logic [7:0] mSeq = 8'd0;
  logic       mOvf = 1'b0;
  int         mFrames = 0;
  logic       bpMode = 1'b0;

  logic [15:0] basicWords [FRAME_WORDS] = '{16'h0010, 16'h1101, 16'h1202, 16'h1303,
                                            16'h1404, 16'h1505, 16'h1606, 16'h1807};
  logic [7:0]  basicExp [19] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h11, 8'h02, 8'h12,
                                 8'h03, 8'h13, 8'h04, 8'h14, 8'h05, 8'h15, 8'h06, 8'h16,
                                 8'h07, 8'h18, 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic frameT genWords(input int k);
    frameT w;
    for (int i = 0; i < FRAME_WORDS; i++) w[i] = 16'(k * 257 + i * 4099 + 85);
    return w;
  endfunction

  // Model: the frame a DUT must emit for these words, nReal of them actually supplied.
  task automatic loadFrame(input frameT w, input int nReal);
    logic [15:0] v;
    expQ.push_back(HDR_BYTE);
    expQ.push_back(mSeq);
    for (int i = 0; i < FRAME_WORDS; i++) begin
      v = (i < nReal) ? w[i] : PAD_WORD;
      if (i < nReal) fifoQ.push_back(w[i]);
      expQ.push_back(v[7:0]);
      expQ.push_back(v[15:8]);
    end
    expQ.push_back({mOvf, (nReal < FRAME_WORDS) ? 1'b1 : 1'b0, 6'd0});
    mSeq = mSeq + 8'd1;
    mOvf = 1'b0;
    mFrames++;
  endtask

  task automatic waitDone(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(expQ.size() == 0 && fifoQ.size() == 0 && !busy)) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_drained"}, expQ.size(), 0);
    chk({name, "_frames_sent"}, frames_sent, 16'(mFrames));
  endtask

  // packBuild read side: DataVal is garbage until RD_LAT cycles after the DataNext cycle
  initial begin : fifoEnv
    int pend, stallLeft, lastAcc;
    logic [15:0] pendWord;
    pend = 0; stallLeft = 0; lastAcc = 0; pendWord = 16'h0;
    DataVal = 16'h0; DataReady = 1'b0; out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) DataVal = pendWord;
        end
        if (DataNext) begin
          nextCnt++;
          chk("next_when_empty", (fifoQ.size() != 0) ? 1 : 0, 1);
          if (fifoQ.size() != 0) pendWord = fifoQ.pop_front();
          DataVal = 16'hDEAD;
          pend = RD_LAT;
        end
      end
      DataReady = (fifoQ.size() != 0);
      if (bpMode) begin
        if (acceptCnt != lastAcc) begin
          lastAcc = acceptCnt;
          if (acceptCnt % 2 == 1) stallLeft = 3;
        end
        if (stallLeft > 0) begin
          out_ready = 1'b0;
          stallLeft--;
        end else out_ready = 1'b1;
      end else begin
        lastAcc = acceptCnt;
        out_ready = 1'b1;
      end
    end
  end

  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h0;
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prevData);
      end
      if (out_valid) chk("busy_with_valid", busy, 1);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) chk("extra_byte", out_data, 32'hFFFF_FFFF);
        else chk("stream_byte", out_data, expQ.pop_front());
        gotQ.push_back(out_data);
        acceptCnt++;
      end
      if (DataFrameReset) frCnt++;
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, fb, n;
    rst = 1'b1; enable = 1'b0; DataOverf = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_next", DataNext, 0);
    chk("rst_frame_reset", DataFrameReset, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frames_sent", frames_sent, 0);
    rst = 1'b0;
    enable = 1'b1;

    // basic frame
    gotQ.delete(); nb = nextCnt;
    loadFrame(basicWords, FRAME_WORDS);
    waitDone(400, "basic");
    chk("basic_len", gotQ.size(), 19);
    for (int i = 0; i < 19; i++) chk("basic_lit", gotQ[i], basicExp[i]);
    chk("basic_frames_lit", frames_sent, 16'd1);
    chk("basic_next_cnt", nextCnt - nb, 8);

    // backpressure, with enable dropped mid-frame
    gotQ.delete(); bpMode = 1'b1;
    loadFrame(basicWords, FRAME_WORDS);
    repeat (10) @(posedge clk);
    #2 enable = 1'b0;
    waitDone(800, "backpressure");
    bpMode = 1'b0; enable = 1'b1;
    chk("bp_len", gotQ.size(), 19);
    for (int i = 0; i < 19; i++) chk("bp_lit", gotQ[i], (i == 1) ? 8'h01 : basicExp[i]);

    // timeout padding
    gotQ.delete(); nb = nextCnt;
    loadFrame(genWords(3), 3);
    waitDone(600, "timeout");
    chk("to_len", gotQ.size(), 19);
    chk("to_pad_lo", gotQ[8], 8'hFF);
    chk("to_pad_hi", gotQ[17], 8'h7F);
    chk("to_status", gotQ[18], 8'h40);
    chk("to_next_cnt", nextCnt - nb, 3);

    // overflow while idle
    fb = frCnt;
    @(posedge clk); #2 DataOverf = 1'b1;
    @(posedge clk); #2 DataOverf = 1'b0;
    mOvf = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("ovf_frame_reset_cnt", frCnt - fb, 1);
    chk("ovf_busy_after", busy, 0);
    gotQ.delete();
    loadFrame(genWords(4), FRAME_WORDS);
    waitDone(400, "ovf1");
    chk("ovf1_status", gotQ[18], 8'h80);
    gotQ.delete();
    loadFrame(genWords(5), FRAME_WORDS);
    waitDone(400, "ovf2");
    chk("ovf2_status", gotQ[18], 8'h00);
    chk("ovf_frames_lit", frames_sent, 16'd5);

    // reset during LO of the fourth word
    gotQ.delete();
    loadFrame(genWords(6), FRAME_WORDS);
    n = 0;
    while (n < 200 && !(out_valid && gotQ.size() == 8)) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rst_mid_reached", (n < 200) ? 1 : 0, 1);
    rst = 1'b1;
    expQ.delete(); fifoQ.delete();
    mSeq = 8'd0; mOvf = 1'b0; mFrames = 0;
    @(posedge clk); #2;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_frames", frames_sent, 0);
    rst = 1'b0;

    // 257 back-to-back frames: sequence wraps, first frame after reset starts A5,00
    gotQ.delete();
    for (int k = 0; k < 257; k++) loadFrame(genWords(k + 10), FRAME_WORDS);
    waitDone(15000, "wrap");
    chk("wrap_len", gotQ.size(), 257 * 19);
    chk("wrap_first_hdr", gotQ[0], 8'hA5);
    chk("wrap_seq0", gotQ[1], 8'h00);
    chk("wrap_seq255", gotQ[19 * 255 + 1], 8'hFF);
    chk("wrap_seq256", gotQ[19 * 256 + 1], 8'h00);
    chk("wrap_frames_lit", frames_sent, 16'd257);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
